// File: rtl/aes128_req_sequencer.sv
// Request sequencer in front of aes128_core: buffers tagged requests, launches them one at a time,
// returns tagged results. Define AES_SEQ_TIMEOUT_EN to add a WAIT-state timeout with error response.
module aes128_req_sequencer #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TAG_W          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_op_i,
    input  logic [127:0]               req_key_i,
    input  logic [127:0]               req_text_i,
    input  logic [TAG_W-1:0]           req_tag_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [127:0]               rsp_text_o,
    output logic [TAG_W-1:0]           rsp_tag_o,
    output logic                       rsp_op_o,
    output logic                       rsp_err_o,
    output logic                       core_start_enc_o,
    output logic                       core_start_dec_o,
    output logic [127:0]               core_key_o,
    output logic [127:0]               core_text_o,
    input  logic                       core_ready_i,
    input  logic                       core_done_i,
    input  logic [127:0]               core_text_i,
    output logic                       busy_o,
    output logic [$clog2(DEPTH):0]     fifo_count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic              push;
    logic              pop;
    logic [TAG_W-1:0]  launch_tag;
    logic              launch_op;

    logic              mem_op   [DEPTH];
    logic [127:0]      mem_key  [DEPTH];
    logic [127:0]      mem_text [DEPTH];
    logic [TAG_W-1:0]  mem_tag  [DEPTH];

    assign push = req_valid_i && req_ready_o;
    assign pop  = (state == StIdle) && (count != '0) && core_ready_i;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    // Ready is registered from the next occupancy, so a same-cycle pop never frees a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            req_ready_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count       <= count_next;
            req_ready_o <= (count_next != FULL_COUNT);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_op[wr_ptr]   <= req_op_i;
            mem_key[wr_ptr]  <= req_key_i;
            mem_text[wr_ptr] <= req_text_i;
            mem_tag[wr_ptr]  <= req_tag_i;
        end
    end

`ifdef AES_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= StIdle;
            core_start_enc_o <= 1'b0;
            core_start_dec_o <= 1'b0;
            core_key_o       <= '0;
            core_text_o      <= '0;
            launch_tag       <= '0;
            launch_op        <= 1'b0;
            rsp_valid_o      <= 1'b0;
            rsp_text_o       <= '0;
            rsp_tag_o        <= '0;
            rsp_op_o         <= 1'b0;
`ifdef AES_SEQ_TIMEOUT_EN
            rsp_err_o        <= 1'b0;
            timer            <= '0;
`endif
        end else begin
            core_start_enc_o <= 1'b0;
            core_start_dec_o <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (pop) begin
                        core_key_o       <= mem_key[rd_ptr];
                        core_text_o      <= mem_text[rd_ptr];
                        launch_tag       <= mem_tag[rd_ptr];
                        launch_op        <= mem_op[rd_ptr];
                        core_start_enc_o <= !mem_op[rd_ptr];
                        core_start_dec_o <= mem_op[rd_ptr];
                        state            <= StWait;
`ifdef AES_SEQ_TIMEOUT_EN
                        timer            <= '0;
`endif
                    end
                end
                StWait: begin
                    // core_ready_i is deliberately ignored here; it may still lag high after a start.
                    if (core_done_i) begin
                        rsp_text_o  <= core_text_i;
                        rsp_tag_o   <= launch_tag;
                        rsp_op_o    <= launch_op;
                        rsp_valid_o <= 1'b1;
                        state       <= StResp;
`ifdef AES_SEQ_TIMEOUT_EN
                        rsp_err_o   <= 1'b0;
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        rsp_text_o  <= '0;
                        rsp_tag_o   <= launch_tag;
                        rsp_op_o    <= launch_op;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        state       <= StResp;
                    end else begin
                        timer       <= timer + TW'(1);
`endif
                    end
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign busy_o       = (state != StIdle) || (count != '0);
    assign fifo_count_o = count;

endmodule

// File: tb/tb_aes128_req_sequencer.sv
// Self-checking bench for aes128_req_sequencer: behavioural core model plus an in-order scoreboard.
module tb_aes128_req_sequencer;

    localparam int unsigned TAG_W = 4;
    localparam int unsigned LAT   = 4;
    localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid_i;
    logic             req_ready_o;
    logic             req_op_i;
    logic [127:0]     req_key_i;
    logic [127:0]     req_text_i;
    logic [TAG_W-1:0] req_tag_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [127:0]     rsp_text_o;
    logic [TAG_W-1:0] rsp_tag_o;
    logic             rsp_op_o;
    logic             rsp_err_o;
    logic             core_start_enc_o;
    logic             core_start_dec_o;
    logic [127:0]     core_key_o;
    logic [127:0]     core_text_o;
    logic             core_ready_i;
    logic             core_done_i;
    logic [127:0]     core_text_i;
    logic             busy_o;
    logic [2:0]       fifo_count_o;

    aes128_req_sequencer #(.DEPTH(4), .TAG_W(TAG_W), .TIMEOUT_CYCLES(64)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_op_i         (req_op_i),
        .req_key_i        (req_key_i),
        .req_text_i       (req_text_i),
        .req_tag_i        (req_tag_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_ready_i      (rsp_ready_i),
        .rsp_text_o       (rsp_text_o),
        .rsp_tag_o        (rsp_tag_o),
        .rsp_op_o         (rsp_op_o),
        .rsp_err_o        (rsp_err_o),
        .core_start_enc_o (core_start_enc_o),
        .core_start_dec_o (core_start_dec_o),
        .core_key_o       (core_key_o),
        .core_text_o      (core_text_o),
        .core_ready_i     (core_ready_i),
        .core_done_i      (core_done_i),
        .core_text_i      (core_text_i),
        .busy_o           (busy_o),
        .fifo_count_o     (fifo_count_o)
    );

    always #5 clk = ~clk;

    int n_pass   = 0;
    int n_checks = 0;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    function automatic logic [127:0] model_f(input logic op, input logic [127:0] key,
                                             input logic [127:0] text);
        if (!op && key == K && text == PT) return CT;
        if (op && key == K && text == CT) return PT;
        return text ^ {key[63:0], key[127:64]} ^ {128{op}};
    endfunction

    // Behavioural core: fixed latency, ready drops the edge after start, hang suppresses done.
    logic         core_hang;
    logic         spurious_done;
    logic         m_busy;
    logic         m_done;
    logic         m_op;
    logic [127:0] m_key;
    logic [127:0] m_text;
    int           m_cnt;

    assign core_done_i = m_done | spurious_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy       <= 1'b0;
            m_done       <= 1'b0;
            m_cnt        <= 0;
            core_ready_i <= 1'b1;
            core_text_i  <= '0;
        end else begin
            m_done <= 1'b0;
            if (core_start_enc_o || core_start_dec_o) begin
                m_busy       <= 1'b1;
                m_cnt        <= LAT;
                core_ready_i <= 1'b0;
                m_op         <= core_start_dec_o;
                m_key        <= core_key_o;
                m_text       <= core_text_o;
            end else if (m_busy && !core_hang) begin
                if (m_cnt == 0) begin
                    m_done       <= 1'b1;
                    core_text_i  <= model_f(m_op, m_key, m_text);
                    m_busy       <= 1'b0;
                    core_ready_i <= 1'b1;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             op;
        logic [127:0]     text;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int   enc_cnt = 0;
    int   dec_cnt = 0;
    logic prev_start = 1'b0;
    logic prev_mdone = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (core_start_enc_o || core_start_dec_o) begin
                chk("start_core_ready", core_ready_i, 1);
                chk("start_single_cycle", prev_start, 0);
                chk("start_onehot", core_start_enc_o & core_start_dec_o, 0);
                if (core_start_enc_o) enc_cnt++;
                if (core_start_dec_o) dec_cnt++;
            end
            if (prev_mdone) chk("rsp_valid_after_done", rsp_valid_o, 1);
            if (rsp_valid_o && rsp_ready_i) begin
                chk("rsp_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_text", rsp_text_o, e.text);
                    chk("rsp_tag", rsp_tag_o, e.tag);
                    chk("rsp_op", rsp_op_o, e.op);
                    chk("rsp_err", rsp_err_o, e.err);
                end
            end
            prev_start = core_start_enc_o | core_start_dec_o;
            prev_mdone = m_done;
        end else begin
            prev_start = 1'b0;
            prev_mdone = 1'b0;
        end
    end

    // Call at posedge+#1; returns at posedge+#1 right after the accepting edge.
    task automatic push(input logic op, input logic [127:0] key, input logic [127:0] text,
                        input logic [TAG_W-1:0] tag, input bit expect_rsp, input bit err);
        bit accepted = 0;
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_key_i   = key;
        req_text_i  = text;
        req_tag_i   = tag;
        if (expect_rsp) sb.push_back('{tag, op, err ? 128'h0 : model_f(op, key, text), err});
        for (int i = 0; i < 300 && !accepted; i++) begin
            @(negedge clk);
            if (req_ready_o) accepted = 1;
        end
        chk("push_accept", accepted, 1);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        bit ok = 0;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy_o && !rsp_valid_o) ok = 1;
        end
        chk("drain", ok, 1);
    endtask

    initial begin
        int          e0;
        int          d0;
        int          s0;
        bit          seen;
        bit          ok;
        logic [127:0] held_text;
        logic [TAG_W-1:0] held_tag;

        rst_n         = 1'b0;
        req_valid_i   = 1'b0;
        req_op_i      = 1'b0;
        req_key_i     = '0;
        req_text_i    = '0;
        req_tag_i     = '0;
        rsp_ready_i   = 1'b1;
        core_hang     = 1'b0;
        spurious_done = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_fifo_count", fifo_count_o, 0);
        chk("rst_starts", {core_start_enc_o, core_start_dec_o}, 0);
        chk("rst_rsp_err", rsp_err_o, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("req_ready_after_rst", req_ready_o, 1);

        // Encrypt with launch latency
        e0 = enc_cnt;
        d0 = dec_cnt;
        push(1'b0, K, PT, 4'd3, 1, 0);
        @(negedge clk);
        chk("lat_no_start_yet", core_start_enc_o, 0);
        chk("lat_count_one", fifo_count_o, 1);
        @(negedge clk);
        chk("lat_start_enc", core_start_enc_o, 1);
        chk("lat_count_zero", fifo_count_o, 0);
        chk("lat_busy", busy_o, 1);
        drain(100);
        chk("enc_pulses", enc_cnt - e0, 1);
        chk("enc_no_dec", dec_cnt - d0, 0);
        @(posedge clk);
        #1;

        // Decrypt
        e0 = enc_cnt;
        d0 = dec_cnt;
        push(1'b1, K, CT, 4'd5, 1, 0);
        drain(100);
        chk("dec_pulses", dec_cnt - d0, 1);
        chk("dec_no_enc", enc_cnt - e0, 0);
        @(posedge clk);
        #1;

        // Full FIFO with response backpressure
        rsp_ready_i = 1'b0;
        e0 = enc_cnt;
        for (int i = 0; i < 5; i++) begin
            push(1'b0, K ^ 128'(i * 7 + 1), PT ^ 128'(i), 4'(i), 1, 0);
        end
        @(negedge clk);
        chk("full_count", fifo_count_o, 4);
        chk("full_not_ready", req_ready_o, 0);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid_o) ok = 1;
        end
        chk("bp_rsp_seen", ok, 1);
        held_text = rsp_text_o;
        held_tag  = rsp_tag_o;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_text_stable", rsp_text_o, held_text);
            chk("bp_valid_held", rsp_valid_o, 1);
        end
        chk("bp_tag_stable", rsp_tag_o, held_tag);
        chk("bp_count_stable", fifo_count_o, 4);
        chk("bp_single_start", enc_cnt - e0, 1);
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b1;
        drain(400);
        chk("full_all_started", enc_cnt - e0, 5);
        @(posedge clk);
        #1;

        // Spurious done in IDLE
        spurious_done = 1'b1;
        @(posedge clk);
        #1;
        spurious_done = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen |= rsp_valid_o;
        end
        chk("spurious_no_rsp", seen, 0);
        chk("spurious_idle", busy_o, 0);
        @(posedge clk);
        #1;

        // Reset while waiting with two queued entries
        core_hang = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(1'b1, K, PT ^ 128'(i + 40), 4'(i + 8), 0, 0);
        end
        @(negedge clk);
        chk("mid_count_two", fifo_count_o, 2);
        chk("mid_busy", busy_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", fifo_count_o, 0);
        chk("mid_rst_rsp_valid", rsp_valid_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        core_hang = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = enc_cnt + dec_cnt;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen |= rsp_valid_o;
        end
        chk("post_rst_no_start", enc_cnt + dec_cnt - s0, 0);
        chk("post_rst_count", fifo_count_o, 0);
        chk("post_rst_no_rsp", seen, 0);
        @(posedge clk);
        #1;

`ifdef AES_SEQ_TIMEOUT_EN
        // Core never completes: error response after 64 WAIT cycles
        core_hang = 1'b1;
        push(1'b0, K, PT, 4'd9, 1, 1);
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (core_start_enc_o) ok = 1;
        end
        chk("to_start_seen", ok, 1);
        s0 = 0;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            s0++;
            if (rsp_valid_o) ok = 1;
        end
        chk("to_rsp_seen", ok, 1);
        chk("to_latency", s0, 64);
        drain(20);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aes128_req_sequencer.md
Name: aes128_req_sequencer

Overview:
- Front-end request sequencer that sits directly upstream of aes128_core.
- Accepts tagged encrypt/decrypt requests over a valid/ready interface and buffers them in a small FIFO.
- Launches requests to the core one at a time, using single-cycle start pulses.
- Captures the core result on done and returns it with its tag over a valid/ready response interface.

Parameters:
- DEPTH, 4, request FIFO entries; power of 2, >= 2.
- TAG_W, 4, width of the request/response tag.
- TIMEOUT_CYCLES, 64, WAIT-state cycle limit; used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request FIFO not full
- req_op_i  in  1  0 = encrypt, 1 = decrypt
- req_key_i  in  128  key
- req_text_i  in  128  plaintext or ciphertext
- req_tag_i  in  TAG_W  request tag
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumer ready
- rsp_text_o  out  128  result text
- rsp_tag_o  out  TAG_W  tag of the completed request
- rsp_op_o  out  1  op of the completed request
- rsp_err_o  out  1  timeout error flag
- core_start_enc_o  out  1  to core start_enc_i
- core_start_dec_o  out  1  to core start_dec_i
- core_key_o  out  128  to core key_i
- core_text_o  out  128  to core text_i
- core_ready_i  in  1  from core ready_o
- core_done_i  in  1  from core done_o
- core_text_i  in  128  from core text_o
- busy_o  out  1  state != IDLE or FIFO non-empty
- fifo_count_o  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - All outputs 0; FIFO empty; state IDLE.
  - req_ready_o rises to 1 on the first clock edge after reset release.
- FIFO:
  - Push when req_valid_i && req_ready_o.
  - req_ready_o = !full, registered. It does not depend on a same-cycle pop (no full-pass-through).
  - Simultaneous push and pop when neither full nor empty: count unchanged.
  - Pointers wrap modulo DEPTH.
  - An entry holds {op, key, text, tag}.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If FIFO non-empty && core_ready_i: pop the head into the launch registers (core_key_o, core_text_o, tag, op).
  - Set core_start_enc_o (op 0) or core_start_dec_o (op 1) high for exactly one cycle.
  - Go to WAIT.
  - Start is never asserted while core_ready_i is 0.
- WAIT:
  - Start outputs return to 0 after one cycle.
  - core_key_o and core_text_o stay stable until exit.
  - core_ready_i is ignored here; its lagging value never triggers a second launch.
  - On core_done_i: capture core_text_i into rsp_text_o, load the launch tag/op into rsp_tag_o/rsp_op_o, set rsp_err_o = 0, go to RESP.
  - rsp_valid_o goes high in the next cycle.
- RESP:
  - rsp_valid_o and all rsp_* outputs are held stable until rsp_ready_i.
  - On handshake: rsp_valid_o drops next cycle and state returns to IDLE. The earliest next launch is the cycle after that.
- Latency:
  - Request pushed into an empty FIFO at edge N with core_ready_i = 1 → start high in cycle N+1.
  - rsp_valid_o rises the cycle after core_done_i.
- core_done_i outside WAIT is ignored; no state change, no response.
- Ordering: responses are returned strictly in request order. Only one request is outstanding at the core at any time.
- Reset mid-operation: FIFO and the in-flight request are dropped silently; no response is produced.

Optional Feature:
- Macro: AES_SEQ_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments every cycle in WAIT.
  - If it reaches TIMEOUT_CYCLES without core_done_i: go to RESP with rsp_err_o = 1, rsp_text_o = 0, and the launch tag/op.
  - If core_done_i arrives in the same cycle as the limit, done wins and rsp_err_o = 0.
  - A late done is then ignored; no new launch occurs until core_ready_i = 1.
- Not defined: no counter; WAIT lasts indefinitely; rsp_err_o is tied to 0.

Test Plan:
- Encrypt: tag 3, op 0, key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff → one start_enc pulse; response text 69c4e0d86a7b0430d8cdb78070b4c55a, tag 3, rsp_err_o 0.
- Decrypt: same key, text 69c4e0d86a7b0430d8cdb78070b4c55a, tag 5, op 1 → one start_dec pulse; response 00112233445566778899aabbccddeeff, tag 5.
- Full FIFO:
  - Push 5 requests back-to-back with DEPTH=4 and rsp_ready_i = 0 → req_ready_o drops once 4 are buffered. The in-flight request empties one slot, so the 5th is accepted only after the first launch.
  - Then release rsp_ready_i → tags return in order 0..4.
- Backpressure: hold rsp_ready_i = 0 for 10 cycles after rsp_valid_o → rsp_* stable, no second start pulse; fifo_count_o unchanged.
- Spurious and missing done:
  - Pulse core_done_i in IDLE → no response.
  - With AES_SEQ_TIMEOUT_EN defined and a core model that never sets done → after 64 WAIT cycles, rsp_err_o = 1 and rsp_text_o = 0.
- Reset mid-operation: assert rst_n low during WAIT with 2 entries queued → after release, fifo_count_o = 0, rsp_valid_o = 0, and no start pulses.
